// File: rtl/riscv_wb_stage_pkg.sv
// Shared types and encodings for the write-back stage: instruction/exception
// bundles, major opcodes, load funct3 encodings and exception cause indices.
package riscv_wb_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

  typedef enum logic [3:0] {
    CAUSE_ILLEGAL_INSTRUCTION = 4'd2,
    CAUSE_LOAD_ACCESS_FAULT   = 4'd5
  } exc_cause_e;

  localparam int EXC_W = 16;

  typedef struct packed {
    logic        bubble;
    logic [31:0] instr;
  } instruction_t;

  typedef struct packed {
    logic [EXC_W-1:0] exceptions;
    logic             any;
  } interrupts_exceptions_t;

  // CSR ops under SYSTEM write rd; ECALL/EBREAK/xRET (funct3 == 0) do not.
  function automatic logic writes_rd(input logic [31:0] instr);
    logic w;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP,
      OPC_LUI, OPC_OP32, OPC_JALR, OPC_JAL: w = 1'b1;
      OPC_SYSTEM:                           w = (instr[14:12] != 3'b000);
      default:                              w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_wb_stage_load_align.sv
// Combinational load aligner: picks the addressed bytes out of the full
// aligned read word and sign/zero-extends them to MXLEN.
module riscv_load_align
  import riscv_wb_stage_pkg::*;
#(
  parameter int MXLEN = 32
) (
  input  logic [2:0]                     funct3_i,
  input  logic [$clog2(MXLEN/8)-1:0]     lane_i,
  input  logic [MXLEN-1:0]               q_i,
  output logic [MXLEN-1:0]               data_o
);

  logic [MXLEN-1:0] shifted;

  assign shifted = q_i >> {lane_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_LB:   data_o = MXLEN'($signed(shifted[7:0]));
      F3_LBU:  data_o = MXLEN'(shifted[7:0]);
      F3_LH:   data_o = MXLEN'($signed(shifted[15:0]));
      F3_LHU:  data_o = MXLEN'(shifted[15:0]);
      F3_LW:   data_o = MXLEN'($signed(shifted[31:0]));
      F3_LWU:  data_o = MXLEN'(shifted[31:0]);
      F3_LD:   data_o = shifted;
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// Write-back stage: registers the retiring instruction, aligns load data,
// stalls upstream while a load response is outstanding and reports faults.
module riscv_wb_stage
  import riscv_wb_stage_pkg::*;
#(
  parameter int MXLEN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  instruction_t           mem_insn_i,
  input  logic [MXLEN-1:0]       mem_r_i,
  input  logic [MXLEN-1:0]       mem_memadr_i,
  input  interrupts_exceptions_t mem_exceptions_i,
  input  logic                   dmem_ack_i,
  input  logic                   dmem_err_i,
  input  logic [MXLEN-1:0]       dmem_q_i,
  output logic                   wb_stall_o,
  output instruction_t           wb_insn_o,
  output logic [MXLEN-1:0]       wb_r_o,
  output logic [4:0]             wb_dst_o,
  output logic                   wb_we_o,
  output interrupts_exceptions_t wb_exceptions_o,
  output logic [MXLEN-1:0]       wb_badaddr_o
);

  localparam int LANE_W = $clog2(MXLEN/8);

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  state_e                 state_q, state_d;
  instruction_t           insn_q, insn_d;
  logic [MXLEN-1:0]       r_q, r_d;
  logic [4:0]             dst_q, dst_d;
  logic                   we_q, we_d;
  interrupts_exceptions_t exc_q, exc_d;
  logic [MXLEN-1:0]       badaddr_q, badaddr_d;

  logic             stall;
  logic             is_load;
  logic             retire_load;
  logic             retire_other;
  logic [4:0]       rd;
  logic [MXLEN-1:0] load_data;

  assign rd      = mem_insn_i.instr[11:7];
  assign is_load = ~mem_insn_i.bubble & (mem_insn_i.instr[6:0] == OPC_LOAD)
                 & ~mem_exceptions_i.any;

  riscv_load_align #(.MXLEN(MXLEN)) u_align (
    .funct3_i (mem_insn_i.instr[14:12]),
    .lane_i   (mem_memadr_i[LANE_W-1:0]),
    .q_i      (dmem_q_i),
    .data_o   (load_data)
  );

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    retire_load  = 1'b0;
    retire_other = 1'b0;
    insn_d       = '{bubble: 1'b1, instr: NOP};
    r_d          = '0;
    dst_d        = '0;
    we_d         = 1'b0;
    exc_d        = '0;
    badaddr_d    = '0;

    case (state_q)
      IDLE: begin
        if (!is_load) begin
          retire_other = 1'b1;
        end else if (dmem_ack_i) begin
          retire_load = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (dmem_ack_i) begin
          retire_load = 1'b1;
          state_d     = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire_other) begin
      insn_d = mem_insn_i;
      r_d    = mem_r_i;
      dst_d  = rd;
      we_d   = ~mem_insn_i.bubble & writes_rd(mem_insn_i.instr) & (rd != 5'd0)
             & ~mem_exceptions_i.any;
      exc_d  = mem_exceptions_i;
    end

    // A bus error still retires (bubble=0) so the state unit can take the trap.
    if (retire_load) begin
      insn_d = '{bubble: 1'b0, instr: mem_insn_i.instr};
      r_d    = load_data;
      dst_d  = rd;
      exc_d  = mem_exceptions_i;
      if (dmem_err_i) begin
        exc_d.exceptions[CAUSE_LOAD_ACCESS_FAULT] = 1'b1;
        exc_d.any                                 = 1'b1;
        badaddr_d                                 = mem_memadr_i;
      end else begin
        we_d = (rd != 5'd0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      insn_q    <= '{bubble: 1'b1, instr: NOP};
      r_q       <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      exc_q     <= '0;
      badaddr_q <= '0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      r_q       <= r_d;
      dst_q     <= dst_d;
      we_q      <= we_d;
      exc_q     <= exc_d;
      badaddr_q <= badaddr_d;
    end
  end

  // Gated by reset so the stall drops the moment reset asserts.
  assign wb_stall_o      = stall & rst_ni;
  assign wb_insn_o       = insn_q;
  assign wb_r_o          = r_q;
  assign wb_dst_o        = dst_q;
  assign wb_we_o         = we_q;
  assign wb_exceptions_o = exc_q;
  assign wb_badaddr_o    = badaddr_q;

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed self-checking bench for riscv_wb_stage (MXLEN=32).
module tb_riscv_wb_stage;
  import riscv_wb_stage_pkg::*;

  logic                   clk;
  logic                   rst_ni;
  instruction_t           mem_insn_i;
  logic [31:0]            mem_r_i;
  logic [31:0]            mem_memadr_i;
  interrupts_exceptions_t mem_exceptions_i;
  logic                   dmem_ack_i;
  logic                   dmem_err_i;
  logic [31:0]            dmem_q_i;
  logic                   wb_stall_o;
  instruction_t           wb_insn_o;
  logic [31:0]            wb_r_o;
  logic [4:0]             wb_dst_o;
  logic                   wb_we_o;
  interrupts_exceptions_t wb_exceptions_o;
  logic [31:0]            wb_badaddr_o;

  int cmp_count  = 0;
  int fail_count = 0;

  riscv_wb_stage #(.MXLEN(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .mem_insn_i       (mem_insn_i),
    .mem_r_i          (mem_r_i),
    .mem_memadr_i     (mem_memadr_i),
    .mem_exceptions_i (mem_exceptions_i),
    .dmem_ack_i       (dmem_ack_i),
    .dmem_err_i       (dmem_err_i),
    .dmem_q_i         (dmem_q_i),
    .wb_stall_o       (wb_stall_o),
    .wb_insn_o        (wb_insn_o),
    .wb_r_o           (wb_r_o),
    .wb_dst_o         (wb_dst_o),
    .wb_we_o          (wb_we_o),
    .wb_exceptions_o  (wb_exceptions_o),
    .wb_badaddr_o     (wb_badaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'd0, f3, rd, opc};
  endfunction

  task automatic drive_mem(input logic bubble, input logic [31:0] instr,
                           input logic [31:0] r, input logic [31:0] adr,
                           input interrupts_exceptions_t exc, input logic ack,
                           input logic err, input logic [31:0] q);
    mem_insn_i       = '{bubble: bubble, instr: instr};
    mem_r_i          = r;
    mem_memadr_i     = adr;
    mem_exceptions_i = exc;
    dmem_ack_i       = ack;
    dmem_err_i       = err;
    dmem_q_i         = q;
  endtask

  task automatic idle_inputs();
    drive_mem(1'b1, NOP, 32'h0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    idle_inputs();
    #1 rst_ni = 1'b0;
    #1;
    cmp_count++;
    if (wb_we_o !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_we got=%b exp=0", wb_we_o); end
    cmp_count++;
    if (wb_dst_o !== 5'd0) begin fail_count++; $display("[TB] FAIL reset_dst got=%0d exp=0", wb_dst_o); end
    cmp_count++;
    if (wb_r_o !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_r got=%h exp=0", wb_r_o); end
    cmp_count++;
    if (wb_insn_o !== {1'b1, 32'h13}) begin fail_count++; $display("[TB] FAIL reset_insn got=%h exp=%h", wb_insn_o, {1'b1, 32'h13}); end
    cmp_count++;
    if (wb_exceptions_o !== '0) begin fail_count++; $display("[TB] FAIL reset_exc got=%h exp=0", wb_exceptions_o); end
    cmp_count++;
    if (wb_badaddr_o !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_badaddr got=%h exp=0", wb_badaddr_o); end
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_stall got=%b exp=0", wb_stall_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_OP, 3'b000, 5'd5), 32'h0000_0007, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL add_stall got=%b exp=0", wb_stall_o); end
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b1) begin fail_count++; $display("[TB] FAIL add_we got=%b exp=1", wb_we_o); end
    cmp_count++;
    if (wb_dst_o !== 5'd5) begin fail_count++; $display("[TB] FAIL add_dst got=%0d exp=5", wb_dst_o); end
    cmp_count++;
    if (wb_r_o !== 32'h7) begin fail_count++; $display("[TB] FAIL add_r got=%h exp=7", wb_r_o); end
    cmp_count++;
    if (wb_insn_o.bubble !== 1'b0) begin fail_count++; $display("[TB] FAIL add_bubble got=%b exp=0", wb_insn_o.bubble); end
  endtask

  task automatic test_load_ack_same_cycle();
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LB, 5'd3), 32'h0, 32'h1003, '0, 1'b1, 1'b0, 32'h8000_0000);
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL lb_stall got=%b exp=0", wb_stall_o); end
    @(posedge clk); #1;
    cmp_count++;
    if (wb_r_o !== 32'hFFFF_FF80) begin fail_count++; $display("[TB] FAIL lb_r got=%h exp=ffffff80", wb_r_o); end
    cmp_count++;
    if (wb_we_o !== 1'b1) begin fail_count++; $display("[TB] FAIL lb_we got=%b exp=1", wb_we_o); end
    cmp_count++;
    if (wb_dst_o !== 5'd3) begin fail_count++; $display("[TB] FAIL lb_dst got=%0d exp=3", wb_dst_o); end

    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LBU, 5'd10), 32'h0, 32'h1003, '0, 1'b1, 1'b0, 32'h8000_0000);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_r_o !== 32'h0000_0080) begin fail_count++; $display("[TB] FAIL lbu_r got=%h exp=00000080", wb_r_o); end

    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LH, 5'd11), 32'h0, 32'h1002, '0, 1'b1, 1'b0, 32'h8001_0000);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_r_o !== 32'hFFFF_8001) begin fail_count++; $display("[TB] FAIL lh_r got=%h exp=ffff8001", wb_r_o); end

    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LW, 5'd7), 32'h0, 32'h1000, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_r_o !== 32'hDEAD_BEEF) begin fail_count++; $display("[TB] FAIL lw_r got=%h exp=deadbeef", wb_r_o); end
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LHU, 5'd4), 32'h0, 32'h1002, '0, 1'b0, 1'b0, 32'hBEEF_1234);
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp_count++;
      if (wb_stall_o !== 1'b1) begin fail_count++; $display("[TB] FAIL lhu_stall_%0d got=%b exp=1", i, wb_stall_o); end
      @(posedge clk); #1;
      cmp_count++;
      if (wb_insn_o.bubble !== 1'b1 || wb_we_o !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL lhu_bubble_%0d got bubble=%b we=%b exp bubble=1 we=0", i, wb_insn_o.bubble, wb_we_o);
      end
      @(negedge clk);
    end
    dmem_ack_i = 1'b1;
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL lhu_ack_stall got=%b exp=0", wb_stall_o); end
    @(posedge clk); #1;
    cmp_count++;
    if (wb_r_o !== 32'h0000_BEEF) begin fail_count++; $display("[TB] FAIL lhu_r got=%h exp=0000beef", wb_r_o); end
    cmp_count++;
    if (wb_we_o !== 1'b1 || wb_dst_o !== 5'd4 || wb_insn_o.bubble !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL lhu_retire got we=%b dst=%0d bubble=%b exp we=1 dst=4 bubble=0", wb_we_o, wb_dst_o, wb_insn_o.bubble);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL lhu_back_idle_stall got=%b exp=0", wb_stall_o); end
  endtask

  task automatic test_load_fault();
    interrupts_exceptions_t exp_exc;
    exp_exc = '0;
    exp_exc.exceptions[CAUSE_LOAD_ACCESS_FAULT] = 1'b1;
    exp_exc.any = 1'b1;
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LW, 5'd6), 32'h0, 32'h2000, '0, 1'b1, 1'b1, 32'h1234_5678);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0) begin fail_count++; $display("[TB] FAIL fault_we got=%b exp=0", wb_we_o); end
    cmp_count++;
    if (wb_exceptions_o !== exp_exc) begin fail_count++; $display("[TB] FAIL fault_exc got=%h exp=%h", wb_exceptions_o, exp_exc); end
    cmp_count++;
    if (wb_badaddr_o !== 32'h2000) begin fail_count++; $display("[TB] FAIL fault_badaddr got=%h exp=2000", wb_badaddr_o); end
    cmp_count++;
    if (wb_insn_o.bubble !== 1'b0) begin fail_count++; $display("[TB] FAIL fault_bubble got=%b exp=0", wb_insn_o.bubble); end
  endtask

  task automatic test_no_write_cases();
    interrupts_exceptions_t up_exc;
    up_exc = '0;
    up_exc.exceptions[CAUSE_ILLEGAL_INSTRUCTION] = 1'b1;
    up_exc.any = 1'b1;

    @(negedge clk);
    drive_mem(1'b0, mk(OPC_OP_IMM, 3'b000, 5'd0), 32'h5, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0) begin fail_count++; $display("[TB] FAIL x0_we got=%b exp=0", wb_we_o); end

    @(negedge clk);
    drive_mem(1'b0, mk(OPC_OP, 3'b000, 5'd9), 32'h99, 32'h0, up_exc, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0) begin fail_count++; $display("[TB] FAIL upexc_we got=%b exp=0", wb_we_o); end
    cmp_count++;
    if (wb_exceptions_o !== up_exc) begin fail_count++; $display("[TB] FAIL upexc_pass got=%h exp=%h", wb_exceptions_o, up_exc); end
    cmp_count++;
    if (wb_badaddr_o !== 32'h0) begin fail_count++; $display("[TB] FAIL upexc_badaddr got=%h exp=0", wb_badaddr_o); end

    // A load carrying an upstream exception must not wait for memory.
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LW, 5'd12), 32'h0, 32'h3000, up_exc, 1'b0, 1'b0, 32'h0);
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL excload_stall got=%b exp=0", wb_stall_o); end
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0 || wb_exceptions_o !== up_exc) begin
      fail_count++;
      $display("[TB] FAIL excload_retire got we=%b exc=%h exp we=0 exc=%h", wb_we_o, wb_exceptions_o, up_exc);
    end

    @(negedge clk);
    drive_mem(1'b1, mk(OPC_LOAD, F3_LW, 5'd13), 32'h0, 32'h3000, '0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0 || wb_insn_o.bubble !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL idle_ack got we=%b bubble=%b exp we=0 bubble=1", wb_we_o, wb_insn_o.bubble);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_mem(1'b0, mk(OPC_LOAD, F3_LW, 5'd8), 32'h0, 32'h4000, '0, 1'b0, 1'b0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    cmp_count++;
    if (wb_stall_o !== 1'b1) begin fail_count++; $display("[TB] FAIL rstwait_pre_stall got=%b exp=1", wb_stall_o); end
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    cmp_count++;
    if (wb_stall_o !== 1'b0) begin fail_count++; $display("[TB] FAIL rstwait_stall got=%b exp=0", wb_stall_o); end
    cmp_count++;
    if (wb_we_o !== 1'b0 || wb_insn_o !== {1'b1, 32'h13} || wb_r_o !== 32'h0 || wb_dst_o !== 5'd0) begin
      fail_count++;
      $display("[TB] FAIL rstwait_outputs got we=%b insn=%h r=%h dst=%0d exp reset values", wb_we_o, wb_insn_o, wb_r_o, wb_dst_o);
    end
    @(posedge clk);
    @(negedge clk);
    drive_mem(1'b1, mk(OPC_LOAD, F3_LW, 5'd8), 32'h0, 32'h4000, '0, 1'b1, 1'b0, 32'hCAFE_F00D);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    cmp_count++;
    if (wb_we_o !== 1'b0 || wb_insn_o.bubble !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL rstwait_late_ack got we=%b bubble=%b exp we=0 bubble=1", wb_we_o, wb_insn_o.bubble);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ack_same_cycle();
    test_load_wait();
    test_load_fault();
    test_no_write_cases();
    test_reset_mid_wait();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
